// File: rtl/route_steer_pkg.sv
// Shared types and route-vector helpers for the route steering stage.
package route_steer_pkg;

   localparam int NUM_PORTS = 3;
   localparam int PORT_W    = $clog2(NUM_PORTS);

   typedef logic [NUM_PORTS-1:0] route_vec_t;
   typedef logic [PORT_W-1:0]    port_idx_t;

   // A route is legal only when exactly one output port is selected.
   function automatic logic route_legal(input route_vec_t r);
      int unsigned n;
      n = 32'd0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         n = n + 32'(r[i]);
      end
      return (n == 32'd1);
   endfunction

   // One-hot to index; the lowest set bit wins for non-one-hot vectors.
   function automatic port_idx_t route_port(input route_vec_t r);
      port_idx_t p;
      p = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (r[i]) begin
            p = port_idx_t'(i);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/route_credit_ctr.sv
// Per-port credit counter: starts full at CREDITS, decrements on send,
// increments on return, and flags a return that would exceed CREDITS.
module route_credit_ctr
   import route_steer_pkg::*;
#(
   parameter int CREDITS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic send,
   input  logic ret,
   output logic has_credit,
   output logic overflow_err
);

   localparam int          CW   = 4;
   localparam logic [CW-1:0] CMAX = CW'(CREDITS);

   logic [CW-1:0] credit_r;
   logic [CW-1:0] credit_nxt_s;

   // Next credit count; send+return together cancel out.
   always_comb begin
      credit_nxt_s = credit_r;
      overflow_err = 1'b0;
      case ({send, ret})
         2'b10: begin
            if (credit_r != 4'd0) begin
               credit_nxt_s = credit_r - 4'd1;
            end else begin
               credit_nxt_s = credit_r;
            end
         end
         2'b01: begin
            if (credit_r == CMAX) begin
               overflow_err = 1'b1;
            end else begin
               credit_nxt_s = credit_r + 4'd1;
            end
         end
         default: credit_nxt_s = credit_r;
      endcase
   end

   // Credit count register, full after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit_r <= CMAX;
      end else begin
         credit_r <= credit_nxt_s;
      end
   end

   assign has_credit = (credit_r != 4'd0);

endmodule

// File: rtl/route_steer_stage.sv
// One-entry registered steering stage: accepts a word with its route
// vector, forwards it to one of three credit-controlled ports, and drops
// (and counts) words whose route is not one-hot.
// Optional macro ROUTE_STEER_STATS_EN adds per-port sent counters (sent_cnt).
module route_steer_stage
   import route_steer_pkg::*;
#(
   parameter int DW      = 32,
   parameter int CREDITS = 4,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DW-1:0]        in_data,
   input  logic [NUM_PORTS-1:0] in_route,
   output logic [NUM_PORTS-1:0] out_valid,
   output logic [DW-1:0]        out_data,
   input  logic [NUM_PORTS-1:0] credit_ret,
   output logic [CNT_W-1:0]     drop_cnt,
   output logic                 credit_err
`ifdef ROUTE_STEER_STATS_EN
   ,
   output logic [NUM_PORTS*CNT_W-1:0] sent_cnt
`endif
);

   logic                 hold_v_r;
   logic [DW-1:0]        hold_data_r;
   route_vec_t           hold_route_r;

   logic                 legal_s;
   port_idx_t            port_s;
   logic                 drain_s;
   logic                 accept_s;
   logic [NUM_PORTS-1:0] send_s;
   logic [NUM_PORTS-1:0] has_credit_s;
   logic [NUM_PORTS-1:0] ovf_s;

   // Drain decision: legal words need credit on their port, illegal words always leave.
   always_comb begin
      legal_s = route_legal(hold_route_r);
      port_s  = route_port(hold_route_r);
      drain_s = 1'b0;
      send_s  = '0;
      if (hold_v_r) begin
         if (legal_s) begin
            drain_s = has_credit_s[port_s];
            if (drain_s) begin
               send_s = hold_route_r;
            end else begin
               send_s = '0;
            end
         end else begin
            drain_s = 1'b1;
         end
      end else begin
         drain_s = 1'b0;
      end
   end

   assign in_ready = !hold_v_r || drain_s;
   assign accept_s = in_valid && in_ready;

   // Stage register: a new word may replace the draining one in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_v_r     <= 1'b0;
         hold_data_r  <= '0;
         hold_route_r <= '0;
      end else if (accept_s) begin
         hold_v_r     <= 1'b1;
         hold_data_r  <= in_data;
         hold_route_r <= in_route;
      end else if (drain_s) begin
         hold_v_r     <= 1'b0;
      end else begin
         hold_v_r     <= hold_v_r;
      end
   end

   // Output strobe/data, saturating drop counter and sticky credit error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= '0;
         out_data   <= '0;
         drop_cnt   <= '0;
         credit_err <= 1'b0;
      end else begin
         out_valid  <= send_s;
         credit_err <= credit_err | (|ovf_s);
         if (|send_s) begin
            out_data <= hold_data_r;
         end
         if (drain_s && !legal_s && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      route_credit_ctr #(.CREDITS(CREDITS)) u_ctr (
         .clk          (clk),
         .rst          (rst),
         .send         (send_s[p]),
         .ret          (credit_ret[p]),
         .has_credit   (has_credit_s[p]),
         .overflow_err (ovf_s[p])
      );

`ifdef ROUTE_STEER_STATS_EN
      // Saturating count of words sent on this port, updated with its strobe.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sent_cnt[p*CNT_W +: CNT_W] <= '0;
         end else if (send_s[p] && (sent_cnt[p*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
            sent_cnt[p*CNT_W +: CNT_W] <= sent_cnt[p*CNT_W +: CNT_W] + CNT_W'(1);
         end
      end
`endif
   end

endmodule

// File: tb/tb_route_steer_stage.sv
// Directed self-checking bench for route_steer_stage.
module tb_route_steer_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic [2:0]  in_route = 3'd0;
   logic [2:0]  out_valid;
   logic [31:0] out_data;
   logic [2:0]  credit_ret = 3'd0;
   logic [15:0] drop_cnt;
   logic        credit_err;
`ifdef ROUTE_STEER_STATS_EN
   logic [47:0] sent_cnt;
`endif

   int total = 0;
   int bad   = 0;
   int n;

   route_steer_stage dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_route   (in_route),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .credit_ret (credit_ret),
      .drop_cnt   (drop_cnt),
      .credit_err (credit_err)
`ifdef ROUTE_STEER_STATS_EN
      ,
      .sent_cnt   (sent_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid   = 1'b0;
      credit_ret = 3'd0;
      rst        = 1'b1;
      tick();
      rst        = 1'b0;
   endtask

   // Offer up to nwords words (data C0DE_0000+i) on one route for ncycles edges;
   // checks each strobe's port and in-order data, returns the strobe count.
   task automatic stream(input logic [2:0] route, input int nwords, input int ncycles,
                         output int strobes);
      int   idx;
      logic acc;
      idx     = 0;
      strobes = 0;
      for (int c = 0; c < ncycles; c++) begin
         in_valid = (idx < nwords);
         in_data  = 32'hC0DE_0000 + 32'(idx);
         in_route = route;
         acc      = in_valid && in_ready;
         tick();
         if (acc) idx++;
         if (out_valid != 3'b000) begin
            chk("stream_port", 64'(out_valid), 64'(route));
            chk("stream_data", 64'(out_data), 64'(32'hC0DE_0000 + 32'(strobes)));
            strobes++;
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("rst_credit_err", 64'(credit_err), 64'd0);

      // Single word to port 1: strobe two edges after presentation
      in_valid = 1'b1; in_data = 32'hA5A5_0001; in_route = 3'b010;
      chk("t1_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("t1_no_strobe_yet", 64'(out_valid), 64'd0);
      tick();
      chk("t1_out_valid", 64'(out_valid), 64'b010);
      chk("t1_out_data", 64'(out_data), 64'hA5A5_0001);
      tick();
      chk("t1_strobe_one_cycle", 64'(out_valid), 64'd0);
`ifdef ROUTE_STEER_STATS_EN
      chk("t1_sent_cnt1", 64'(sent_cnt[31:16]), 64'd1);
`endif
      // Port 1 now has 3 credits: 3 sends, then stall
      stream(3'b010, 4, 6, n);
      chk("t1_credit3_sends", 64'(n), 64'd3);
      chk("t1_credit3_stall", 64'(in_ready), 64'd0);

      // Six words on port 0 with no returns
      do_reset();
      stream(3'b001, 6, 6, n);
      chk("t2_strobes", 64'(n), 64'd4);
      chk("t2_blocked", 64'(in_ready), 64'd0);
      in_valid = 1'b1; in_data = 32'hC0DE_0005; in_route = 3'b001;
      credit_ret = 3'b001;
      tick();
      credit_ret = 3'b000;
      chk("t2_ret_no_strobe", 64'(out_valid), 64'd0);
      chk("t2_ret_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("t2_fifth_valid", 64'(out_valid), 64'b001);
      chk("t2_fifth_data", 64'(out_data), 64'hC0DE_0004);

      // Illegal routes are dropped without strobes
      do_reset();
      in_valid = 1'b1; in_data = 32'h1111_0000; in_route = 3'b000;
      chk("t3_ready_a", 64'(in_ready), 64'd1);
      tick();
      in_data = 32'h1111_0001; in_route = 3'b011;
      chk("t3_ready_b", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("t3_no_strobe_a", 64'(out_valid), 64'd0);
      chk("t3_ready_c", 64'(in_ready), 64'd1);
      tick();
      chk("t3_no_strobe_b", 64'(out_valid), 64'd0);
      chk("t3_drop_cnt", 64'(drop_cnt), 64'd2);
      chk("t3_ready_d", 64'(in_ready), 64'd1);

      // Port 2 credit exhaustion, return, and simultaneous send+return
      do_reset();
      stream(3'b100, 5, 6, n);
      chk("t4_strobes", 64'(n), 64'd4);
      chk("t4_blocked", 64'(in_ready), 64'd0);
      credit_ret = 3'b100;
      tick();
      credit_ret = 3'b000;
      chk("t4_ret_ready", 64'(in_ready), 64'd1);
      tick();
      chk("t4_sent_valid", 64'(out_valid), 64'b100);
      chk("t4_sent_data", 64'(out_data), 64'hC0DE_0004);
      credit_ret = 3'b100;
      tick();
      tick();
      credit_ret = 3'b000;
      in_valid = 1'b1; in_data = 32'h2222_0002; in_route = 3'b100;
      tick();
      in_valid = 1'b0;
      credit_ret = 3'b100;
      chk("t4_sr_ready", 64'(in_ready), 64'd1);
      tick();
      credit_ret = 3'b000;
      chk("t4_sr_valid", 64'(out_valid), 64'b100);
      chk("t4_sr_data", 64'(out_data), 64'h2222_0002);
      stream(3'b100, 4, 6, n);
      chk("t4_credit2_sends", 64'(n), 64'd2);
      chk("t4_credit2_stall", 64'(in_ready), 64'd0);
      chk("t4_no_err", 64'(credit_err), 64'd0);

      // Return at full credit sets a sticky error and does not add credit
      do_reset();
      credit_ret = 3'b001;
      tick();
      credit_ret = 3'b000;
      chk("t5_err_set", 64'(credit_err), 64'd1);
      tick(); tick();
      chk("t5_err_sticky", 64'(credit_err), 64'd1);
      stream(3'b001, 5, 6, n);
      chk("t5_credit_still4", 64'(n), 64'd4);
      chk("t5_err_still", 64'(credit_err), 64'd1);

      // Asynchronous reset while port 1 is blocked with a held word
      do_reset();
      in_valid = 1'b1; in_data = 32'h3333_0000; in_route = 3'b000;
      tick();
      in_valid = 1'b0;
      tick();
      chk("t6_pre_drop", 64'(drop_cnt), 64'd1);
      stream(3'b010, 5, 6, n);
      chk("t6_pre_blocked", 64'(in_ready), 64'd0);
      #2 rst = 1'b1;
      #1;
      chk("t6_hold_cleared", 64'(in_ready), 64'd1);
      chk("t6_drop_cleared", 64'(drop_cnt), 64'd0);
      chk("t6_valid_cleared", 64'(out_valid), 64'd0);
`ifdef ROUTE_STEER_STATS_EN
      chk("t6_sent_cleared", 64'(sent_cnt), 64'd0);
`endif
      #1 rst = 1'b0;
      tick();
      chk("t6_no_strobe_a", 64'(out_valid), 64'd0);
      tick();
      chk("t6_no_strobe_b", 64'(out_valid), 64'd0);
      chk("t6_drop_still0", 64'(drop_cnt), 64'd0);
      stream(3'b010, 5, 6, n);
      chk("t6_credit_restored", 64'(n), 64'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/route_steer_stage.md
Name: route_steer_stage

Overview:
- Registered steering stage directly downstream of the combinational route-compute block.
- Takes one packet word plus its 3-bit route vector (route bit p = output port p) under valid/ready handshake, holds it in a one-entry stage register, and forwards it to exactly one of three credit-flow-controlled output ports.
- Drops words whose route vector is illegal and counts them.

Parameters:
- DW, 32, packet word width.
- CREDITS, 4, initial and maximum credit count per output port (legal range 1..15).
- CNT_W, 16, width of the drop counter and the optional statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept the word this cycle.
- in_data  in  DW  packet word.
- in_route  in  3  route vector from route compute; one-hot is legal.
- out_valid  out  3  one-cycle strobe per port; port p owns bit p.
- out_data  out  DW  word for the port currently strobed; shared by all ports.
- credit_ret  in  3  one-cycle credit return per port.
- drop_cnt  out  CNT_W  count of illegal-route drops; saturating.
- credit_err  out  1  sticky flag: a credit was returned while that port's count was at CREDITS.

Behaviour:
- Reset (asynchronous, active-high):
  - hold_v=0, out_valid=0, out_data=0.
  - credit[p]=CREDITS for every port.
  - drop_cnt=0, credit_err=0.
  - Reset asserted mid-operation discards any held word; the word is not counted as a drop.
- Stage register holds hold_v, hold_data and hold_route.
- Legal route: popcount(hold_route)==1. Illegal route: 3'b000 or popcount>1.
- drain (combinational), true when either:
  - hold_v and the route is legal and credit[p]>0 for the selected port p; or
  - hold_v and the route is illegal.
- in_ready = !hold_v || drain. This is combinational from registered state only; it never depends on in_valid.
- Accept: in_valid && in_ready. At the edge, the stage register loads in_data/in_route and sets hold_v=1.
- Drain and accept in the same cycle: the new word replaces the old one, giving back-to-back throughput of 1 word/cycle.
- Drain with a legal route, at the edge:
  - out_valid <= hold_route (exactly one bit set).
  - out_data <= hold_data.
  - credit[p] decrements.
- Drain with an illegal route, at the edge:
  - out_valid <= 0.
  - drop_cnt increments, saturating at all-ones.
- No drain: out_valid <= 0 and out_data keeps its previous value.
- Latency: word accepted at edge N; out_valid is high in the cycle after edge N+1, provided credit is available.
- Blocking: a legal word whose port has zero credit stalls the stage. in_ready stays 0, with no bypass to other ports (no reordering).
- Credit update per port each edge: credit = credit − send + ret.
  - Send and return together leave the count unchanged.
  - A return while the count is at CREDITS and no send occurs: the count stays at CREDITS and credit_err is set. credit_err clears only on reset.
- in_data and in_route are sampled only on accept. Values presented while in_ready=0 are ignored.

Optional Feature:
- Macro: ROUTE_STEER_STATS_EN.
- Defined:
  - Adds output sent_cnt [3*CNT_W-1:0], one saturating counter per port, in slice p.
  - Slice p increments on every out_valid[p] strobe and resets to 0.
- Undefined:
  - The port and the counters are absent.
  - All other behaviour is identical.

Decomposition:
- Package route_steer_pkg contains:
  - NUM_PORTS=3.
  - typedef route_vec_t (logic [NUM_PORTS-1:0]).
  - function route_legal(route_vec_t), the popcount==1 check.
  - function route_port(route_vec_t), returning a one-hot-to-index port number.
- Sub-module route_credit_ctr, instantiated once per port:
  - Inputs: send, ret.
  - Outputs: has_credit, overflow_err.
  - Parameterised by CREDITS.

Test Plan:
- Reset, then in_valid=1, in_data=32'hA5A5_0001, in_route=3'b010 → in_ready=1; out_valid=3'b010 with out_data=32'hA5A5_0001 two edges later; credit[1]=3.
- Stream 6 words, all route 3'b001, credit_ret=0 → 4 strobes on port 0, then in_ready=0 while a word is held; one credit_ret[0] pulse → 5th word sent on the next edge.
- Routes 3'b000 then 3'b011 → no out_valid strobe; drop_cnt=2; in_ready stays 1 throughout.
- Port 2 at 0 credits with a held word, credit_ret[2] pulsed → word sent next edge; credit_ret[2] and send in the same cycle with credit=2 → credit remains 2.
- credit_ret[0] pulsed right after reset (credit=4) → credit_err=1 and stays 1; credit stays 4.
- rst pulsed while a word is held and port 1 is at 0 credits → hold_v=0, all credits=4, drop_cnt=0, no strobe follows; with ROUTE_STEER_STATS_EN, sent_cnt=0.
